multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control unit of the multicycle MIPS datapath, directly upstream of the ALU control stage. A Moore FSM sequences fetch, decode, execute, memory and writeback from the 6-bit opcode. It drives all datapath enables, mux selects and the 2-bit ALUOp that the ALU control decodes together with funct. A mem_ready input stalls it on slow memory accesses.

Parameters:
STATE_W, 4, width of the state register; must hold every state of the largest build (with MC_ADDI_EN).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
opcode  input  6  instr[31:26] from IR
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC write
pc_write_cond  output  1  PC write if ALU zero (beq)
i_or_d  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  latch instruction register
mem_to_reg  output  1  writeback source: 0=ALUOut, 1=MDR
reg_dst  output  1  dest reg: 0=rt, 1=rd
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  output  2  00=add, 01=sub, 10=use funct
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  output  1  one-cycle pulse: undefined opcode decoded
state_dbg  output  STATE_W  current state, debug only

Behaviour:
- rst asserted: state=FETCH immediately, illegal_op=0. Outputs are pure state decode, so during reset they read as FETCH values with pc_write=ir_write=0 (mem_ready is ignored while rst=1).
- State register updates on rising clk when rst=0. Every output is a function of state only, except the mem_ready gating below.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) / 101011 (sw) -> MEM_ADDR
  - 000000 -> EXEC_R
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 in the following cycle only (registered pulse)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Hold while mem_ready=0; then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold while mem_ready=0; then -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH.
- JUMP: pc_write=1, pc_source=10; -> FETCH.
- Any output not listed for a state is 0.
- Instruction latency in cycles, excluding wait states: lw 5, sw 4, R 4, beq 3, j 3.
- Unreachable state encodings -> FETCH on next clock.
- rst asserted mid-instruction aborts the instruction with no write strobe on the following cycle.

Optional Feature:
- Macro MC_ADDI_EN.
- Defined: opcode 001000 in DECODE -> ADDI_EX (alu_src_a=1, alu_src_b=10, alu_op=00) -> ADDI_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH. Latency 4.
- Undefined: 001000 is treated as illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Package mc_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state encodings S_FETCH..S_ADDI_WB
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
- One combinational sub-module, mc_output_decode: maps state plus mem_ready to the control outputs. The top level keeps the state register, next-state logic and the illegal_op flop.

Test Plan:
- Reset, then lw (100011) with mem_ready tied 1 -> FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB,FETCH; reg_write=1 and mem_to_reg=1 only in cycle 5.
- R-type (000000) -> alu_op=10 exactly in the EXEC_R cycle; reg_write=1 with reg_dst=1 in the next cycle; 4 cycles total.
- beq (000100) -> BRANCH shows alu_op=01, pc_write_cond=1, pc_source=01; j (000010) -> pc_write=1, pc_source=10; both 3 cycles.
- sw with mem_ready=0 for 3 cycles in MEM_WR -> mem_write held 4 cycles and no state advance until mem_ready=1; FETCH with mem_ready=0 -> ir_write=pc_write=0.
- Opcode 111111 -> return to FETCH after DECODE, illegal_op=1 for exactly one cycle. Opcode 001000 -> ADDI path when MC_ADDI_EN is defined, illegal pulse otherwise.
- Assert rst asynchronously in MEM_RD -> state_dbg=FETCH before the next edge and no reg_write pulse follows.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control unit.
// Build option MC_ADDI_EN adds the ADDI_EX/ADDI_WB path for opcode 001000.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Encodings 12..15 are never entered; the FSM recovers from them to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode of the control FSM; only FETCH looks at mem_ready.
// ADDI states decode only when MC_ADDI_EN is defined.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_source
);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_REG;
        o_alu_op        = ALUOP_ADD;
        o_pc_source     = PCSRC_ALU;
        case (state_t'(i_state))
            S_FETCH: begin
                // PC+4 and IR latch commit only when the fetch completes.
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                o_reg_write = 1'b1;
                o_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOP_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PCSRC_JUMP;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                o_reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, next-state
// logic and the registered illegal-opcode pulse. Option: MC_ADDI_EN.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_illegal;
    logic   w_mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_EXEC_R;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      w_next = S_ADDI_EX;
`endif
                    default:      w_illegal = 1'b1;
                endcase
            end
            // IR still holds the instruction here, so opcode picks load vs store.
            S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   w_next = S_R_WB;
`ifdef MC_ADDI_EN
            S_ADDI_EX:  w_next = S_ADDI_WB;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Reset forces FETCH, and masking mem_ready keeps its strobes quiet meanwhile.
    assign w_mem_ready = mem_ready & ~rst;

    mc_output_decode u_decode (
        .i_state         (r_state),
        .i_mem_ready     (w_mem_ready),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_i_or_d        (i_or_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_source     (pc_source)
    );

    assign illegal_op = r_illegal;
    assign state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations go through a
// scoreboard queue and are compared with immediate assertions.
module tb_multicycle_control;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;
    logic [15:0] w_ctl;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
    //  reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source}
    assign w_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   errs   = 0;
    int   checks = 0;

    function automatic logic [15:0] ctl_of(input state_t s, input logic mr);
        case (s)
            S_FETCH:    return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            S_DECODE:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
            S_MEM_ADDR: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            S_MEM_RD:   return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            S_MEM_WB:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            S_MEM_WR:   return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
            S_EXEC_R:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            S_R_WB:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            S_BRANCH:   return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            S_JUMP:     return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
            S_ADDI_EX:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00};
            S_ADDI_WB:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            default:    return 16'h0000;
        endcase
    endfunction

    task automatic push(input state_t s, input logic mr, input logic ill);
        exp_t e;
        e.st  = s;
        e.ctl = ctl_of(s, mr);
        e.ill = ill;
        q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        checks++;
        assert (q.size() != 0) else begin
            errs++;
            $error("FAIL %s scoreboard empty got=%0d required=1", tag, q.size());
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            assert (state_dbg === e.st) else begin
                errs++;
                $error("FAIL %s state got=%0d required=%0d", tag, state_dbg, e.st);
            end
            checks++;
            assert (w_ctl === e.ctl) else begin
                errs++;
                $error("FAIL %s ctl got=%b required=%b", tag, w_ctl, e.ctl);
            end
            checks++;
            assert (illegal_op === e.ill) else begin
                errs++;
                $error("FAIL %s illegal_op got=%b required=%b", tag, illegal_op, e.ill);
            end
        end
    endtask

    // Called at a falling edge: drive inputs, check the current state's outputs,
    // then advance to the next falling edge.
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input state_t s, input logic ill);
        opcode    = op;
        mem_ready = mr;
        #1;
        push(s, mr, ill);
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = OP_RTYPE;
        mem_ready = 1'b1;
        @(negedge clk);
        push(S_FETCH, 1'b0, 1'b0);
        check("reset");
        rst = 1'b0;

        step("lw_f",   OP_LW, 1'b1, S_FETCH,    1'b0);
        step("lw_d",   OP_LW, 1'b1, S_DECODE,   1'b0);
        step("lw_a",   OP_LW, 1'b1, S_MEM_ADDR, 1'b0);
        step("lw_r",   OP_LW, 1'b1, S_MEM_RD,   1'b0);
        step("lw_wb",  OP_LW, 1'b1, S_MEM_WB,   1'b0);

        step("r_f",    OP_RTYPE, 1'b1, S_FETCH,  1'b0);
        step("r_d",    OP_RTYPE, 1'b1, S_DECODE, 1'b0);
        step("r_ex",   OP_RTYPE, 1'b1, S_EXEC_R, 1'b0);
        step("r_wb",   OP_RTYPE, 1'b1, S_R_WB,   1'b0);

        step("beq_f",  OP_BEQ, 1'b1, S_FETCH,  1'b0);
        step("beq_d",  OP_BEQ, 1'b1, S_DECODE, 1'b0);
        step("beq_br", OP_BEQ, 1'b1, S_BRANCH, 1'b0);

        step("j_f",    OP_J, 1'b1, S_FETCH,  1'b0);
        step("j_d",    OP_J, 1'b1, S_DECODE, 1'b0);
        step("j_j",    OP_J, 1'b1, S_JUMP,   1'b0);

        step("sw_f",   OP_SW, 1'b1, S_FETCH,    1'b0);
        step("sw_d",   OP_SW, 1'b1, S_DECODE,   1'b0);
        step("sw_a",   OP_SW, 1'b1, S_MEM_ADDR, 1'b0);
        step("sw_w0",  OP_SW, 1'b0, S_MEM_WR,   1'b0);
        step("sw_w1",  OP_SW, 1'b0, S_MEM_WR,   1'b0);
        step("sw_w2",  OP_SW, 1'b0, S_MEM_WR,   1'b0);
        step("sw_w3",  OP_SW, 1'b1, S_MEM_WR,   1'b0);
        step("f_st0",  OP_SW, 1'b0, S_FETCH,    1'b0);
        step("f_st1",  OP_SW, 1'b0, S_FETCH,    1'b0);

        step("ill_f",  6'h3F, 1'b1, S_FETCH,  1'b0);
        step("ill_d",  6'h3F, 1'b1, S_DECODE, 1'b0);
        step("ill_p",  6'h3F, 1'b1, S_FETCH,  1'b1);
        step("addi_d", OP_ADDI, 1'b1, S_DECODE, 1'b0);
`ifdef MC_ADDI_EN
        step("addi_ex", OP_ADDI, 1'b1, S_ADDI_EX, 1'b0);
        step("addi_wb", OP_ADDI, 1'b1, S_ADDI_WB, 1'b0);
        step("addi_f",  OP_LW,   1'b1, S_FETCH,   1'b0);
`else
        step("addi_ill", OP_LW, 1'b1, S_FETCH, 1'b1);
`endif

        step("rs_d",   OP_LW, 1'b1, S_DECODE,   1'b0);
        step("rs_a",   OP_LW, 1'b1, S_MEM_ADDR, 1'b0);
        step("rs_r0",  OP_LW, 1'b0, S_MEM_RD,   1'b0);
        step("rs_r1",  OP_LW, 1'b0, S_MEM_RD,   1'b0);

        // Asynchronous reset mid-load: FETCH must show before any clock edge.
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        push(S_FETCH, 1'b0, 1'b0);
        check("rst_async");
        @(negedge clk);
        rst = 1'b0;
        step("rs_f0",  OP_LW, 1'b0, S_FETCH, 1'b0);
        step("rs_f1",  OP_LW, 1'b0, S_FETCH, 1'b0);

        checks++;
        assert (q.size() == 0) else begin
            errs++;
            $error("FAIL sb_drain leftover got=%0d required=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
